// File: rtl/adc_sample_fifo_pkg.sv
// Shared types and helpers for the ADC capture FIFO: FSM states, default
// sizing, and the offset-binary to two's-complement conversion.
package adc_sample_fifo_pkg;

   localparam int DEF_DATA_W = 10;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   // Offset binary to two's complement is a flip of the sample MSB; the caller
   // passes its real width and keeps only the low bits of the result.
   function automatic logic [31:0] offset_to_signed(input logic [31:0] raw,
                                                    input int unsigned width);
      return raw ^ (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/adc_sample_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head entry is always visible on
// rd_data while empty_n is high; level and empty_n are registered.
module sync_fifo_fwft #(
   parameter int W     = 10,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty_n,
   output logic          full,
   output logic [AW:0]   level
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_ptr_nx;
   logic [AW:0]  rd_ptr_nx;
   logic         pop;
   logic         push;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign full      = (level == (AW + 1)'(DEPTH));
   assign pop       = rd_en & empty_n;
   assign push      = wr_en & (~full | pop);
   assign wr_ptr_nx = wr_ptr + (AW + 1)'(push);
   assign rd_ptr_nx = rd_ptr + (AW + 1)'(pop);
   assign rd_data   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         empty_n <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr_nx;
         rd_ptr  <= rd_ptr_nx;
         level   <= wr_ptr_nx - rd_ptr_nx;
         empty_n <= (wr_ptr_nx != rd_ptr_nx);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC capture front end: arms a capture window, converts samples to signed,
// queues them in a FWFT FIFO for an ap_fifo consumer, and flags drops.
module adc_sample_fifo
   import adc_sample_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              arm,
   input  logic              abort,
   input  logic [CNT_W-1:0]  capture_len,
   input  logic              clear_ovf,
   output logic [DATA_W-1:0] datain_V_dout,
   output logic              datain_V_empty_n,
   input  logic              datain_V_read,
   output logic [LW-1:0]     fill_level,
   output logic              overflow,
   output logic              busy,
   output logic              capture_done,
   output state_t            state
);

   state_t            state_nx;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nx;
   logic              attempt;
   logic              pop;
   logic              full;
   logic              drop;
   logic              done_nx;
   logic [DATA_W-1:0] wr_data;

   assign attempt = (state == CAPTURE) & adc_valid;
   assign pop     = datain_V_read & datain_V_empty_n;
   assign drop    = attempt & full & ~pop;
   assign wr_data = DATA_W'(offset_to_signed(32'(adc_data), DATA_W));

   sync_fifo_fwft #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .wr_en   (attempt),
      .wr_data (wr_data),
      .rd_en   (datain_V_read),
      .rd_data (datain_V_dout),
      .empty_n (datain_V_empty_n),
      .full    (full),
      .level   (fill_level)
   );

   // The length test uses the post-increment count so exactly capture_len
   // attempts are taken before the window closes.
   always_comb begin
      state_nx = state;
      count_nx = count;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               state_nx = CAPTURE;
               count_nx = '0;
            end
         end
         CAPTURE: begin
            if (attempt && (count != '1)) begin
               count_nx = count + 1'b1;
            end
            if (abort || ((capture_len != '0) && (count_nx == capture_len))) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (!datain_V_empty_n) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state        <= IDLE;
         count        <= '0;
         overflow     <= 1'b0;
         busy         <= 1'b0;
         capture_done <= 1'b0;
      end else begin
         state        <= state_nx;
         count        <= count_nx;
         busy         <= (state_nx != IDLE);
         capture_done <= done_nx;
         overflow     <= drop | (overflow & ~clear_ovf);
      end
   end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed and randomized bench for adc_sample_fifo against a queue-based
// reference model of the capture window, FIFO and overflow flag.
module tb_adc_sample_fifo;
   import adc_sample_fifo_pkg::*;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [9:0]  adc_data;
   logic        adc_valid;
   logic        arm;
   logic        abort;
   logic [15:0] capture_len;
   logic        clear_ovf;
   logic [9:0]  datain_V_dout;
   logic        datain_V_empty_n;
   logic        datain_V_read;
   logic [4:0]  fill_level;
   logic        overflow;
   logic        busy;
   logic        capture_done;
   state_t      state;

   int total = 0;
   int bad = 0;
   int done_pulses = 0;

   logic [9:0] exp_q[$];
   state_t     m_state = IDLE;
   int         m_cnt = 0;
   bit         m_ovf = 0;
   bit         m_done = 0;

   always #5 ap_clk = ~ap_clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   adc_sample_fifo dut (
      .ap_clk           (ap_clk),
      .ap_rst           (ap_rst),
      .adc_data         (adc_data),
      .adc_valid        (adc_valid),
      .arm              (arm),
      .abort            (abort),
      .capture_len      (capture_len),
      .clear_ovf        (clear_ovf),
      .datain_V_dout    (datain_V_dout),
      .datain_V_empty_n (datain_V_empty_n),
      .datain_V_read    (datain_V_read),
      .fill_level       (fill_level),
      .overflow         (overflow),
      .busy             (busy),
      .capture_done     (capture_done),
      .state            (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: advances one clock using the inputs currently driven.
   task automatic model_step();
      bit pop;
      bit attempt;
      bit store;
      bit drop;
      int sz;
      sz = exp_q.size();
      if (ap_rst) begin
         exp_q.delete();
         m_state = IDLE;
         m_cnt   = 0;
         m_ovf   = 0;
         m_done  = 0;
         return;
      end
      pop     = datain_V_read && (sz > 0);
      attempt = (m_state == CAPTURE) && adc_valid;
      store   = attempt && ((sz < 16) || pop);
      drop    = attempt && !store;
      m_done  = 0;
      case (m_state)
         IDLE: if (arm) begin
            m_state = CAPTURE;
            m_cnt   = 0;
         end
         CAPTURE: begin
            if (attempt && (m_cnt < 65535)) m_cnt++;
            if (abort || ((capture_len != 16'd0) && (m_cnt == 32'(capture_len)))) m_state = DRAIN;
         end
         default: if (sz == 0) begin
            m_state = IDLE;
            m_done  = 1;
         end
      endcase
      if (pop) void'(exp_q.pop_front());
      if (store) exp_q.push_back(10'(adc_data - 10'd512));
      if (drop) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge ap_clk);
      #1;
      if (capture_done) done_pulses++;
      check("fill_level", 32'(fill_level), 32'(exp_q.size()));
      check("empty_n", 32'(datain_V_empty_n), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("dout", 32'(datain_V_dout), 32'(exp_q[0]));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_state != IDLE));
      check("capture_done", 32'(capture_done), 32'(m_done));
      check("state", 32'(state), 32'(m_state));
   endtask

   task automatic quiet();
      ap_rst        = 0;
      arm           = 0;
      abort         = 0;
      adc_valid     = 0;
      datain_V_read = 0;
      clear_ovf     = 0;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      quiet();
      datain_V_read = 1;
      while (((m_state != IDLE) || (exp_q.size() != 0)) && (n < max_cycles)) begin
         cycle();
         n++;
      end
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_empty", 32'(datain_V_empty_n), 32'd0);
      datain_V_read = 0;
   endtask

   task automatic push_samples(input int n);
      adc_valid = 1;
      for (int i = 0; i < n; i++) begin
         adc_data = 10'($urandom_range(0, 1023));
         cycle();
      end
      adc_valid = 0;
   endtask

   task automatic start_capture(input logic [15:0] len);
      quiet();
      capture_len = len;
      arm = 1;
      cycle();
      arm = 0;
   endtask

   initial begin
      logic [9:0] samples [4];
      samples[0] = 10'd512;
      samples[1] = 10'd513;
      samples[2] = 10'd511;
      samples[3] = 10'd0;

      // Reset, with arm held during the second reset cycle.
      quiet();
      capture_len = 0;
      adc_data    = 0;
      ap_rst      = 1;
      cycle();
      arm = 1;
      cycle();
      quiet();
      cycle();
      check("arm_during_rst", 32'(state), 32'(IDLE));

      // Four-sample capture with the consumer always reading.
      done_pulses = 0;
      start_capture(16'd4);
      datain_V_read = 1;
      adc_valid     = 1;
      for (int i = 0; i < 4; i++) begin
         adc_data = samples[i];
         cycle();
      end
      check("len4_state", 32'(state), 32'(DRAIN));
      drain(20);
      check("len4_done_pulses", 32'(done_pulses), 32'd1);

      // Continuous capture overflows after 16 samples.
      start_capture(16'd0);
      push_samples(20);
      check("ovf_fill", 32'(fill_level), 32'd16);
      check("ovf_flag", 32'(overflow), 32'd1);

      // Full FIFO with write and pop together: level holds, no drop.
      clear_ovf = 1;
      cycle();
      clear_ovf     = 0;
      adc_valid     = 1;
      datain_V_read = 1;
      adc_data      = 10'($urandom_range(0, 1023));
      cycle();
      check("full_rw_fill", 32'(fill_level), 32'd16);
      check("full_rw_ovf", 32'(overflow), 32'd0);
      quiet();
      abort = 1;
      cycle();
      drain(40);

      // Read on empty is ignored; write plus read on empty leaves one entry.
      datain_V_read = 1;
      cycle();
      check("empty_read_fill", 32'(fill_level), 32'd0);
      start_capture(16'd0);
      adc_valid     = 1;
      datain_V_read = 1;
      adc_data      = 10'd700;
      cycle();
      check("empty_rw_fill", 32'(fill_level), 32'd1);
      check("empty_rw_dout", 32'(datain_V_dout), 32'd188);
      quiet();
      abort = 1;
      cycle();
      drain(10);

      // Abort after 3 of 10 samples.
      done_pulses = 0;
      start_capture(16'd10);
      push_samples(3);
      abort = 1;
      cycle();
      abort = 0;
      check("abort_state", 32'(state), 32'(DRAIN));
      check("abort_fill", 32'(fill_level), 32'd3);
      drain(10);
      check("abort_done_pulses", 32'(done_pulses), 32'd1);

      // Reset mid-capture discards the contents and ignores a concurrent arm.
      start_capture(16'd0);
      push_samples(5);
      ap_rst = 1;
      arm    = 1;
      cycle();
      quiet();
      check("rst_fill", 32'(fill_level), 32'd0);
      check("rst_empty_n", 32'(datain_V_empty_n), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      cycle();

      // A drop in the same cycle as clear_ovf leaves overflow set.
      start_capture(16'd0);
      push_samples(16);
      adc_valid = 1;
      clear_ovf = 1;
      cycle();
      check("clr_vs_drop", 32'(overflow), 32'd1);
      quiet();
      abort = 1;
      cycle();
      drain(40);
      clear_ovf = 1;
      cycle();
      check("clr_ovf", 32'(overflow), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ((m_state == IDLE) && ($urandom_range(0, 7) == 0)) begin
            capture_len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
            arm = 1;
         end else begin
            arm = 0;
         end
         abort         = ($urandom_range(0, 29) == 0);
         adc_valid     = ($urandom_range(0, 9) < 7);
         adc_data      = 10'($urandom_range(0, 1023));
         datain_V_read = ($urandom_range(0, 9) < 4);
         clear_ovf     = ($urandom_range(0, 9) == 0);
         ap_rst        = ($urandom_range(0, 149) == 0);
         cycle();
      end
      quiet();
      abort = 1;
      cycle();
      drain(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 Parameter DATA_W, default 10, ADC sample width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries (power of two).
REQ-003 Parameter CNT_W, default 16, capture length and counter width.
REQ-004 ap_clk  in  1  sole clock; all logic on rising edge.
REQ-005 ap_rst  in  1  reset, synchronous, active-high.
REQ-006 adc_data  in  DATA_W  raw ADC sample, offset binary (512 = zero).
REQ-007 adc_valid  in  1  adc_data valid this cycle.
REQ-008 arm  in  1  one-cycle pulse that starts a capture.
REQ-009 abort  in  1  one-cycle pulse that ends a capture.
REQ-010 capture_len  in  CNT_W  samples per capture; 0 = continuous.
REQ-011 clear_ovf  in  1  clears the sticky overflow flag.
REQ-012 datain_V_dout  out  DATA_W  head sample, two's complement.
REQ-013 datain_V_empty_n  out  1  high when FIFO holds at least one sample.
REQ-014 datain_V_read  in  1  consumer pop strobe (ap_fifo read side).
REQ-015 fill_level  out  log2(DEPTH)+1  current occupancy.
REQ-016 overflow  out  1  sticky flag: a sample was dropped.
REQ-017 busy  out  1  high in CAPTURE or DRAIN.
REQ-018 capture_done  out  1  one-cycle pulse at DRAIN->IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE and DRAIN.
REQ-020 IDLE->CAPTURE on arm; the sample counter is cleared to 0 at the same edge.
REQ-021 CAPTURE->DRAIN when the counter reaches capture_len (nonzero) or on abort.
REQ-022 DRAIN->IDLE when the FIFO is empty, asserting capture_done for exactly one cycle.
REQ-023 arm SHALL be ignored outside IDLE; abort SHALL be ignored outside CAPTURE.
REQ-024 Only in CAPTURE, a cycle with adc_valid=1 SHALL be a write attempt and increment the counter (saturating at all-ones), whether or not the write is stored.
REQ-025 Stored data SHALL equal adc_data with the MSB inverted (equivalent to adc_data-512 mod 2^DATA_W); no saturation.
REQ-026 The FIFO SHALL be first-word-fall-through: datain_V_dout SHALL show the head entry whenever datain_V_empty_n=1.
REQ-027 datain_V_dout SHALL be don't-care when datain_V_empty_n=0; a write into an empty FIFO SHALL appear at the head on the next cycle.
REQ-028 A pop SHALL occur when datain_V_read=1 and datain_V_empty_n=1; datain_V_read while empty SHALL be ignored.
REQ-029 A write SHALL be stored when not full, or when full and a pop occurs in the same cycle.
REQ-030 Simultaneous write and pop SHALL leave fill_level unchanged.
REQ-031 A write attempt when full with no pop SHALL be dropped and SHALL set overflow on the next cycle.
REQ-032 overflow SHALL clear on clear_ovf unless a drop occurs in the same cycle (set wins).
REQ-033 Read and write pointers SHALL wrap modulo DEPTH; an extra MSB SHALL distinguish full from empty.
REQ-034 fill_level SHALL equal the write-minus-read pointer difference; full = DEPTH.
REQ-035 Outputs fill_level, datain_V_empty_n, overflow and busy SHALL be registered.

Reset
REQ-036 While ap_rst=1: state=IDLE, pointers=0, counter=0, fill_level=0, datain_V_empty_n=0, overflow=0, busy=0, capture_done=0.
REQ-037 ap_rst asserted mid-capture SHALL discard all FIFO contents, and the block SHALL ignore arm until the cycle after ap_rst deasserts.
REQ-038 Memory contents need no reset.

Structure
REQ-039 The package SHALL hold the FSM state enum, the default DATA_W/DEPTH/CNT_W constants and the offset-to-signed conversion function.
REQ-040 The storage SHALL be one sub-module, sync_fifo_fwft (memory, pointers, level); the FSM, counter, conversion and overflow logic live in the top level.

Verification
REQ-041 arm, capture_len=4, samples 512,513,511,0, read held high -> dout sequence 0,1,-1,-512; capture_done pulses once; busy then low.
REQ-042 capture_len=0, 20 continuous adc_valid, no reads -> fill_level=16, overflow=1, first 16 samples retained in order.
REQ-043 Full FIFO, adc_valid and datain_V_read in the same cycle -> fill_level stays 16, overflow stays 0, new sample at the tail.
REQ-044 Empty FIFO, datain_V_read=1 -> no pointer change, fill_level=0; write and read same cycle on empty -> fill_level=1 next cycle.
REQ-045 abort after 3 of capture_len=10 samples -> DRAIN; capture_done asserts after the 3 entries are popped.
REQ-046 ap_rst pulsed with 5 entries stored in CAPTURE -> next cycle fill_level=0, empty_n=0, state IDLE; a same-cycle clear_ovf and drop -> overflow=1.
